multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle main controller for the MIPS datapath. It takes the opcode/funct fields produced by the instruction field splitter and sequences the PC, IR, register file, ALU and data memory through FETCH/DECODE/EXEC/MEM/WB states. It drives all mux selects and write enables, and stalls on a memory ready handshake. Supported ISA: addu, subu, sll-nop, jr, ori, lui, lw, sw, beq, j, jal.

Parameters:
MEM_HANDSHAKE, 1, 1 = wait on mem_ready in MEM state; 0 = treat mem_ready as constant 1
STATE_W, 3, width of state register and of the debug state output

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  instr[31:26] from splitter (IR output)
funct  in  6  instr[5:0] from splitter
zero  in  1  ALU equality flag (rs==rt), valid in EXEC
mem_ready  in  1  data memory ack; sampled in MEM
pc_we  out  1  PC write enable
pc_src  out  2  0 PC+4, 1 branch target, 2 {PC[31:28],imm26,2'b0}, 3 GPR[rs]
ir_we  out  1  IR load enable
reg_we  out  1  register file write enable
reg_dst  out  2  0 rt, 1 rd, 2 $31
wd_src  out  2  0 ALU result, 1 memory data, 2 PC (already PC+4)
alu_src  out  1  0 GPR[rt], 1 extended imm16
alu_op  out  3  0 ADD, 1 SUB, 2 OR, 3 PASS-B
ext_op  out  2  0 zero-ext, 1 sign-ext, 2 imm16<<16
mem_re  out  1  data memory read strobe
mem_we  out  1  data memory write strobe
illegal  out  1  one-cycle pulse on unsupported encoding
state  out  STATE_W  current state (debug)

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Values 6-7 are unreachable and go to FETCH.
- Reset (reset=0, async): state=IDLE. All outputs are 0, including selects. IDLE -> FETCH unconditionally on the next edge after release.
- Outputs are a combinational (Moore plus opcode) decode of state, opcode and funct. opcode/funct are stable from DECODE onward because IR loads only in FETCH.
- FETCH: ir_we=1, pc_we=1, pc_src=0 -> DECODE.
- DECODE:
  - j: pc_we=1, pc_src=2 -> FETCH.
  - jal: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wd_src=2 -> FETCH. The register write uses PC before update.
  - jr (R, funct 001000): pc_we=1, pc_src=3 -> FETCH.
  - sll with funct 000000 (nop): -> FETCH, no writes.
  - illegal opcode/funct: illegal=1 for one cycle, no writes -> FETCH.
  - Others -> EXEC.
- EXEC:
  - addu: alu_op=0, alu_src=0.
  - subu: alu_op=1, alu_src=0.
  - ori: alu_op=2, alu_src=1, ext_op=0.
  - lui: alu_op=3, alu_src=1, ext_op=2.
  - lw/sw: alu_op=0, alu_src=1, ext_op=1 -> MEM.
  - beq: alu_op=1, ext_op=1. pc_we=zero, pc_src=1 -> FETCH.
  - R/ori/lui -> WB.
- MEM: lw asserts mem_re, sw asserts mem_we, with EXEC alu settings held. Stay in MEM while mem_ready=0; strobes stay high throughout.
  - On mem_ready=1: sw -> FETCH, lw -> WB.
- WB: reg_we=1.
  - R: reg_dst=1, wd_src=0.
  - ori/lui: reg_dst=0, wd_src=0.
  - lw: reg_dst=0, wd_src=1.
  - All -> FETCH.
- Cycles per instruction with no waits: j/jal/jr/nop/illegal 2; beq 3; R/ori/lui 4; sw 4; lw 5. Each mem_ready=0 cycle adds 1.
- Never asserted together: reg_we with mem_we; pc_we outside FETCH/DECODE/EXEC. ir_we is asserted only in FETCH.
- Reset asserted mid-instruction: immediate return to IDLE, strobes drop asynchronously, and the partial instruction is abandoned.
- mem_ready outside MEM is ignored.

Decomposition:
- Package mips_ctrl_pkg:
  - opcode constants: R 000000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011
  - funct constants: addu 100001, subu 100011, jr 001000, sll 000000
  - state encodings
  - pc_src/reg_dst/wd_src/alu_op/ext_op codes
- Sub-module ctrl_decode (combinational): opcode/funct -> one-hot instruction class plus illegal. Used by the FSM for next-state and output decode.

Test Plan:
- Reset low for 3 cycles, then release: all outputs 0 during reset; state sequence 0,1,2.
- addu (000000/100001): FETCH ir_we=pc_we=1 -> DECODE -> EXEC alu_op=0 -> WB reg_we=1, reg_dst=1, wd_src=0; back to FETCH after 4 cycles.
- lw with mem_ready low 2 cycles: MEM held 3 cycles with mem_re=1, mem_we=0 throughout; WB reg_dst=0, wd_src=1; 7 cycles total. sw with mem_ready=1: mem_we for 1 cycle, no reg_we.
- beq with zero=1: pc_we=1, pc_src=1 in EXEC. beq with zero=0: pc_we=0 in EXEC. Both return to FETCH on cycle 4.
- jal: DECODE pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wd_src=2. jr: pc_src=3. Each instruction 2 cycles.
- opcode 111111: illegal=1 for exactly one cycle in DECODE, no enables -> FETCH. Reset pulled low during a lw MEM stall: mem_re drops immediately; state=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared encodings for the multi-cycle MIPS controller.
//   - opcode / funct constants for the supported subset
//   - FSM state encoding
//   - select codes for pc_src, reg_dst, wd_src, alu_op, ext_op
//   - instr_cls_t : one-hot instruction class produced by ctrl_decode
//   - ctrl_t      : bundle of every control output driven by the FSM
package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_SLL  = 6'b000000;

    // Encodings 6 and 7 are deliberately left unnamed; the FSM's default
    // branch sends them to FETCH.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [1:0] PC_SRC_INC  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_REG  = 2'd3;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] WD_SRC_ALU = 2'd0;
    localparam logic [1:0] WD_SRC_MEM = 2'd1;
    localparam logic [1:0] WD_SRC_PC  = 2'd2;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_HI   = 2'd2;

    // Exactly one bit is set for any opcode/funct pair.
    typedef struct packed {
        logic addu;
        logic subu;
        logic nop;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic illegal;
    } instr_cls_t;

    typedef struct packed {
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_src;
        logic       alu_src;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic       mem_re;
        logic       mem_we;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational classifier for the instruction held in IR.
//   opcode : instr[31:26]
//   funct  : instr[5:0] (only meaningful for R-type)
//   cls    : one-hot instruction class; cls.illegal for any unsupported encoding
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output instr_cls_t  cls
);

    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_R: begin
                unique case (funct)
                    FN_ADDU: cls.addu    = 1'b1;
                    FN_SUBU: cls.subu    = 1'b1;
                    FN_JR:   cls.jr      = 1'b1;
                    // Only sll is decoded, and it is treated as a nop
                    // whatever the shift amount.
                    FN_SLL:  cls.nop     = 1'b1;
                    default: cls.illegal = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori     = 1'b1;
            OP_LUI:  cls.lui     = 1'b1;
            OP_LW:   cls.lw      = 1'b1;
            OP_SW:   cls.sw      = 1'b1;
            OP_BEQ:  cls.beq     = 1'b1;
            OP_J:    cls.j       = 1'b1;
            OP_JAL:  cls.jal     = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle
// MIPS datapath.
//   clk, reset (async, active low)
//   opcode, funct      : IR fields, stable from DECODE onward
//   zero               : ALU equality flag, used by beq in EXEC
//   mem_ready          : data memory ack, only looked at in MEM
//   pc_we/pc_src, ir_we, reg_we/reg_dst/wd_src, alu_src/alu_op/ext_op,
//   mem_re/mem_we      : datapath controls
//   illegal            : one-cycle pulse in DECODE on an unsupported encoding
//   state              : current state (debug)
// Outputs are decoded combinationally from state + instruction class, so
// every control drops together with the state register when reset asserts.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int STATE_W       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               ir_we,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wd_src,
    output logic               alu_src,
    output logic [2:0]         alu_op,
    output logic [1:0]         ext_op,
    output logic               mem_re,
    output logic               mem_we,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_e     state_q, state_d;
    instr_cls_t cls;
    ctrl_t      c;
    logic       rdy;

    ctrl_decode u_dec (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
    );

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        c       = '0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                c.ir_we  = 1'b1;
                c.pc_we  = 1'b1;
                c.pc_src = PC_SRC_INC;
                state_d  = ST_DECODE;
            end

            ST_DECODE: begin
                state_d = ST_EXEC;
                if (cls.j) begin
                    c.pc_we  = 1'b1;
                    c.pc_src = PC_SRC_JUMP;
                    state_d  = ST_FETCH;
                end else if (cls.jal) begin
                    // PC already holds PC+4 from FETCH; it is written to $31
                    // on the same edge that loads the jump target.
                    c.pc_we   = 1'b1;
                    c.pc_src  = PC_SRC_JUMP;
                    c.reg_we  = 1'b1;
                    c.reg_dst = REG_DST_RA;
                    c.wd_src  = WD_SRC_PC;
                    state_d   = ST_FETCH;
                end else if (cls.jr) begin
                    c.pc_we  = 1'b1;
                    c.pc_src = PC_SRC_REG;
                    state_d  = ST_FETCH;
                end else if (cls.nop) begin
                    state_d = ST_FETCH;
                end else if (cls.illegal) begin
                    c.illegal = 1'b1;
                    state_d   = ST_FETCH;
                end
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                if (cls.addu) begin
                    c.alu_op = ALU_ADD;
                    state_d  = ST_WB;
                end else if (cls.subu) begin
                    c.alu_op = ALU_SUB;
                    state_d  = ST_WB;
                end else if (cls.ori) begin
                    c.alu_op  = ALU_OR;
                    c.alu_src = 1'b1;
                    c.ext_op  = EXT_ZERO;
                    state_d   = ST_WB;
                end else if (cls.lui) begin
                    c.alu_op  = ALU_PASS;
                    c.alu_src = 1'b1;
                    c.ext_op  = EXT_HI;
                    state_d   = ST_WB;
                end else if (cls.lw || cls.sw) begin
                    c.alu_op  = ALU_ADD;
                    c.alu_src = 1'b1;
                    c.ext_op  = EXT_SIGN;
                    state_d   = ST_MEM;
                end else if (cls.beq) begin
                    // ALU compares rs-rt; the branch adder uses the
                    // sign-extended offset, hence ext_op even with alu_src=0.
                    c.alu_op = ALU_SUB;
                    c.ext_op = EXT_SIGN;
                    c.pc_we  = zero;
                    c.pc_src = PC_SRC_BR;
                end
            end

            ST_MEM: begin
                // Address calculation is held so the memory sees a stable
                // address for the whole stall.
                c.alu_op  = ALU_ADD;
                c.alu_src = 1'b1;
                c.ext_op  = EXT_SIGN;
                c.mem_re  = cls.lw;
                c.mem_we  = cls.sw;
                if (rdy) state_d = cls.lw ? ST_WB : ST_FETCH;
            end

            ST_WB: begin
                c.reg_we  = 1'b1;
                c.reg_dst = (cls.addu || cls.subu) ? REG_DST_RD : REG_DST_RT;
                c.wd_src  = cls.lw ? WD_SRC_MEM : WD_SRC_ALU;
                state_d   = ST_FETCH;
            end

            default: state_d = ST_FETCH;
        endcase
    end

    assign pc_we   = c.pc_we;
    assign pc_src  = c.pc_src;
    assign ir_we   = c.ir_we;
    assign reg_we  = c.reg_we;
    assign reg_dst = c.reg_dst;
    assign wd_src  = c.wd_src;
    assign alu_src = c.alu_src;
    assign alu_op  = c.alu_op;
    assign ext_op  = c.ext_op;
    assign mem_re  = c.mem_re;
    assign mem_we  = c.mem_we;
    assign illegal = c.illegal;
    assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pc_we, ir_we, reg_we, alu_src, mem_re, mem_we, illegal;
    logic [1:0] pc_src, reg_dst, wd_src, ext_op;
    logic [2:0] alu_op, state;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .STATE_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we),
        .reg_dst(reg_dst), .wd_src(wd_src), .alu_src(alu_src),
        .alu_op(alu_op), .ext_op(ext_op), .mem_re(mem_re), .mem_we(mem_we),
        .illegal(illegal), .state(state)
    );

    // Expected visible behaviour for one clock cycle.
    typedef struct packed {
        logic [2:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_src;
        logic       alu_src;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic       mem_re;
        logic       mem_we;
        logic       illegal;
    } exp_t;

    typedef enum int {K_ADDU, K_SUBU, K_NOP, K_JR, K_ORI, K_LUI,
                      K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL} kind_e;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   first_ill = 1'b1;

    function automatic exp_t blank(logic [2:0] st);
        exp_t e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
        if (op == 6'b000000)
            return fn inside {6'b100001, 6'b100011, 6'b001000, 6'b000000};
        return op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011,
                          6'b000100, 6'b000010, 6'b000011};
    endfunction

    task automatic encode(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (k)
            K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
            K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
            K_NOP:  begin op = 6'b000000; fn = 6'b000000; end
            K_JR:   begin op = 6'b000000; fn = 6'b001000; end
            K_ORI:  op = 6'b001101;
            K_LUI:  op = 6'b001111;
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_JAL:  op = 6'b000011;
            default: begin
                if (first_ill) begin
                    op = 6'b111111;
                    first_ill = 1'b0;
                end else begin
                    do begin
                        op = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
                        fn = 6'($urandom);
                    end while (is_legal(op, fn));
                end
            end
        endcase
    endtask

    // One clock: drive this cycle's inputs just after the edge and record
    // what the outputs must look like for the rest of the cycle.
    task automatic step(input exp_t e, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy);
        @(posedge clk);
        #1;
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        sbq.push_back(e);
    endtask

    task automatic run_reset(input int n);
        reset = 1'b0;
        repeat (n) step(blank(3'd0), 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.push_back(blank(3'd0));
    endtask

    // Cycle-by-cycle expectation of one instruction, from the ISA table:
    // FETCH, DECODE, then EXEC/MEM(+waits)/WB as the instruction needs.
    task automatic run_instr(input kind_e k, input logic z, input int waits, input bit abort_mem);
        logic [5:0] op, fn;
        exp_t e;
        encode(k, op, fn);

        e = blank(3'd1); e.ir_we = 1; e.pc_we = 1;
        step(e, 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));

        e = blank(3'd2);
        case (k)
            K_J:   begin e.pc_we = 1; e.pc_src = 2; end
            K_JAL: begin e.pc_we = 1; e.pc_src = 2; e.reg_we = 1; e.reg_dst = 2; e.wd_src = 2; end
            K_JR:  begin e.pc_we = 1; e.pc_src = 3; end
            K_ILL: e.illegal = 1;
            default: ;
        endcase
        step(e, op, fn, 1'($urandom), 1'($urandom));
        if (k inside {K_J, K_JAL, K_JR, K_NOP, K_ILL}) return;

        e = blank(3'd3);
        case (k)
            K_SUBU: e.alu_op = 1;
            K_ORI:  begin e.alu_op = 2; e.alu_src = 1; end
            K_LUI:  begin e.alu_op = 3; e.alu_src = 1; e.ext_op = 2; end
            K_LW, K_SW: begin e.alu_src = 1; e.ext_op = 1; end
            K_BEQ:  begin e.alu_op = 1; e.ext_op = 1; e.pc_we = z; e.pc_src = 1; end
            default: ;
        endcase
        step(e, op, fn, z, 1'($urandom));
        if (k == K_BEQ) return;

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= waits; i++) begin
                e = blank(3'd4); e.alu_src = 1; e.ext_op = 1;
                e.mem_re = (k == K_LW); e.mem_we = (k == K_SW);
                step(e, op, fn, 1'($urandom), (i == waits));
                if (abort_mem) begin
                    #1;
                    checks++;
                    if (mem_re !== 1'b1) begin
                        failures++;
                        $display("FAIL pre_reset_mem_re got=%b exp=1", mem_re);
                    end
                    reset = 1'b0;
                    #1;
                    checks++;
                    if (mem_re !== 1'b0 || mem_we !== 1'b0 || state !== 3'd0) begin
                        failures++;
                        $display("FAIL async_reset got mem_re=%b mem_we=%b state=%0d exp 0/0/0",
                                 mem_re, mem_we, state);
                    end
                    sbq.delete();
                    run_reset(2);
                    return;
                end
            end
            if (k == K_SW) return;
        end

        e = blank(3'd5); e.reg_we = 1;
        e.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        e.wd_src  = (k == K_LW) ? 2'd1 : 2'd0;
        step(e, op, fn, 1'($urandom), 1'($urandom));
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t a, e;
        cyc++;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = {state, pc_we, pc_src, ir_we, reg_we, reg_dst, wd_src,
                 alu_src, alu_op, ext_op, mem_re, mem_we, illegal};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle%0d outputs got=%h exp=%h (state got %0d exp %0d)",
                         cyc, a, e, a.st, e.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        run_reset(3);
        run_instr(K_ADDU, 1'b0, 0, 1'b0);
        run_instr(K_LW,   1'b0, 2, 1'b0);
        run_instr(K_SW,   1'b0, 0, 1'b0);
        run_instr(K_BEQ,  1'b1, 0, 1'b0);
        run_instr(K_BEQ,  1'b0, 0, 1'b0);
        run_instr(K_JAL,  1'b0, 0, 1'b0);
        run_instr(K_JR,   1'b0, 0, 1'b0);
        run_instr(K_ILL,  1'b0, 0, 1'b0);
        run_instr(K_LW,   1'b0, 3, 1'b1);
        for (int i = 0; i < 300; i++)
            run_instr(kind_e'($urandom_range(0, 11)), 1'($urandom), $urandom_range(0, 3), 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
